stream_max_reduce: RTL and testbench

- Sequential max-reduction stage directly upstream of the mux primitive.
- Consumes a valid/ready stream of fixed-point words and compares each accepted beat against a running maximum. That compare result is the select key for the mux.
- After N_BEATS accepted beats it emits one result holding the group maximum and its argmax index.
- Used for max-pool and argmax heads after a dense layer.

---
 rtl/stream_max_reduce.sv | 61 ++++++
 tb/tb_stream_max_reduce.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/stream_max_reduce.sv
// stream_max_reduce: running max/argmax over groups of N_BEATS accepted beats.
// Define STREAM_MAX_REDUCE_RELU_EN to clamp negative results to 0 when SIGNED=1.
module stream_max_reduce #(
    parameter int BW_IN   = 16,
    parameter int SIGNED  = 1,
    parameter int N_BEATS = 4,
    parameter int BW_IDX  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BW_IN-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BW_IN-1:0]  out_data,
    output logic [BW_IDX-1:0] out_index
);
    localparam logic [BW_IDX-1:0] LAST = BW_IDX'(N_BEATS - 1);
    logic [BW_IN-1:0]  acc, nxt_val, res;
    logic [BW_IDX-1:0] cnt, acc_idx, nxt_idx;
    logic              gt, take, accept, last;
    always_comb begin
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;
        last     = cnt == LAST;
        gt       = (SIGNED != 0) ? ($signed(in_data) > $signed(acc)) : (in_data > acc);
        // The first beat of a group seeds the accumulator regardless of the compare.
        take     = (cnt == '0) || gt;
        nxt_val  = take ? in_data : acc;
        nxt_idx  = take ? cnt : acc_idx;
`ifdef STREAM_MAX_REDUCE_RELU_EN
        res      = ((SIGNED != 0) && nxt_val[BW_IN-1]) ? '0 : nxt_val;
`else
        res      = nxt_val;
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            cnt       <= '0;
            acc       <= '0;
            acc_idx   <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                acc     <= nxt_val;
                acc_idx <= nxt_idx;
                cnt     <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    out_valid <= 1'b1;
                    out_data  <= res;
                    out_index <= nxt_idx;
                end
            end
        end
    end
endmodule

// File: tb/tb_stream_max_reduce.sv
// tb_stream_max_reduce: directed checks of signed/unsigned max-reduce and single-beat groups.
module tb_stream_max_reduce;
    logic        clk, rst, in_valid, out_ready;
    logic [15:0] in_data;
    logic        s_in_ready, s_out_valid, u_in_ready, u_out_valid, o_in_ready, o_out_valid;
    logic [15:0] s_out_data, u_out_data, o_out_data;
    logic [1:0]  s_out_index, u_out_index;
    logic [0:0]  o_out_index;
    int nvec = 0;
    int nerr = 0;
`ifdef STREAM_MAX_REDUCE_RELU_EN
    localparam logic [15:0] NEG_RES = 16'h0000;
`else
    localparam logic [15:0] NEG_RES = 16'hFFFF;
`endif

    stream_max_reduce #(.BW_IN(16), .SIGNED(1), .N_BEATS(4), .BW_IDX(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_index(s_out_index));
    stream_max_reduce #(.BW_IN(16), .SIGNED(0), .N_BEATS(4), .BW_IDX(2)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready), .in_data(in_data),
        .out_valid(u_out_valid), .out_ready(out_ready), .out_data(u_out_data), .out_index(u_out_index));
    stream_max_reduce #(.BW_IN(16), .SIGNED(1), .N_BEATS(1), .BW_IDX(1)) dut_one (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_in_ready), .in_data(in_data),
        .out_valid(o_out_valid), .out_ready(out_ready), .out_data(o_out_data), .out_index(o_out_index));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b1;
        idle(); idle();
        rst = 1'b0;
        nvec++; if (s_out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b exp 0", s_out_valid); end
        nvec++; if (s_out_data !== 16'h0) begin nerr++; $display("FAIL reset_data got %h exp 0000", s_out_data); end
        nvec++; if (s_out_index !== 2'd0) begin nerr++; $display("FAIL reset_index got %0d exp 0", s_out_index); end
        nvec++; if (s_in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %b exp 1", s_in_ready); end
    endtask

    task automatic test_basic();
        send(16'd3); send(16'hFFFB); send(16'd7);
        nvec++; if (s_out_valid !== 1'b0) begin nerr++; $display("FAIL basic_early_valid got %b exp 0", s_out_valid); end
        send(16'd2);
        nvec++; if (s_out_valid !== 1'b1) begin nerr++; $display("FAIL basic_valid got %b exp 1", s_out_valid); end
        nvec++; if (s_out_data !== 16'd7) begin nerr++; $display("FAIL basic_data got %h exp 0007", s_out_data); end
        nvec++; if (s_out_index !== 2'd2) begin nerr++; $display("FAIL basic_index got %0d exp 2", s_out_index); end
        nvec++; if (u_out_data !== 16'hFFFB) begin nerr++; $display("FAIL basic_u_data got %h exp fffb", u_out_data); end
        nvec++; if (u_out_index !== 2'd1) begin nerr++; $display("FAIL basic_u_index got %0d exp 1", u_out_index); end
        idle();
        nvec++; if (s_out_valid !== 1'b0) begin nerr++; $display("FAIL basic_valid_drop got %b exp 0", s_out_valid); end
    endtask

    task automatic test_ties();
        send(16'd5); send(16'd5); send(16'd1); send(16'd5);
        nvec++; if (s_out_data !== 16'd5) begin nerr++; $display("FAIL tie_data got %h exp 0005", s_out_data); end
        nvec++; if (s_out_index !== 2'd0) begin nerr++; $display("FAIL tie_index got %0d exp 0", s_out_index); end
        idle();
    endtask

    task automatic test_sign_mode();
        send(16'h0001); send(16'hFFFF); send(16'h8000); send(16'h0002);
        nvec++; if (u_out_data !== 16'hFFFF) begin nerr++; $display("FAIL unsigned_data got %h exp ffff", u_out_data); end
        nvec++; if (u_out_index !== 2'd1) begin nerr++; $display("FAIL unsigned_index got %0d exp 1", u_out_index); end
        nvec++; if (s_out_data !== 16'h0002) begin nerr++; $display("FAIL signed_data got %h exp 0002", s_out_data); end
        nvec++; if (s_out_index !== 2'd3) begin nerr++; $display("FAIL signed_index got %0d exp 3", s_out_index); end
        idle();
    endtask

    task automatic test_relu();
        send(16'hFFFD); send(16'hFFF7); send(16'hFFFF); send(16'hFFF9);
        nvec++; if (s_out_data !== NEG_RES) begin nerr++; $display("FAIL relu_data got %h exp %h", s_out_data, NEG_RES); end
        nvec++; if (s_out_index !== 2'd2) begin nerr++; $display("FAIL relu_index got %0d exp 2", s_out_index); end
        nvec++; if (u_out_data !== 16'hFFFF) begin nerr++; $display("FAIL relu_u_data got %h exp ffff", u_out_data); end
        idle();
    endtask

    task automatic test_backpressure();
        send(16'd10); send(16'd20); send(16'd30);
        send(16'd40);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'd99;
        nvec++; if (s_out_data !== 16'd40) begin nerr++; $display("FAIL bp_data got %h exp 0028", s_out_data); end
        for (int i = 0; i < 5; i++) begin
            idle();
            nvec++; if (s_in_ready !== 1'b0) begin nerr++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, s_in_ready); end
            nvec++; if (s_out_valid !== 1'b1 || s_out_data !== 16'd40 || s_out_index !== 2'd3)
                begin nerr++; $display("FAIL bp_hold[%0d] got v=%b d=%h i=%0d exp v=1 d=0028 i=3", i, s_out_valid, s_out_data, s_out_index); end
        end
        out_ready = 1'b1;
        #1;
        nvec++; if (s_in_ready !== 1'b1) begin nerr++; $display("FAIL bp_release_ready got %b exp 1", s_in_ready); end
        send(16'd99);
        nvec++; if (s_out_valid !== 1'b0) begin nerr++; $display("FAIL bp_handshake_drop got %b exp 0", s_out_valid); end
        send(16'd1); send(16'd2); send(16'd3);
        nvec++; if (s_out_valid !== 1'b1 || s_out_data !== 16'd99 || s_out_index !== 2'd0)
            begin nerr++; $display("FAIL bp_next_group got v=%b d=%h i=%0d exp v=1 d=0063 i=0", s_out_valid, s_out_data, s_out_index); end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [15:0] beats [8] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd9, 16'd8, 16'd7, 16'd6};
        for (int i = 0; i < 8; i++) begin
            nvec++; if (s_in_ready !== 1'b1) begin nerr++; $display("FAIL b2b_in_ready[%0d] got %b exp 1", i, s_in_ready); end
            send(beats[i]);
            nvec++; if (o_out_valid !== 1'b1 || o_out_data !== beats[i] || o_out_index !== 1'b0)
                begin nerr++; $display("FAIL one_beat[%0d] got v=%b d=%h i=%0d exp v=1 d=%h i=0", i, o_out_valid, o_out_data, o_out_index, beats[i]); end
            if (i == 3) begin
                nvec++; if (s_out_valid !== 1'b1 || s_out_data !== 16'd4 || s_out_index !== 2'd3)
                    begin nerr++; $display("FAIL b2b_first got v=%b d=%h i=%0d exp v=1 d=0004 i=3", s_out_valid, s_out_data, s_out_index); end
            end
        end
        nvec++; if (s_out_valid !== 1'b1 || s_out_data !== 16'd9 || s_out_index !== 2'd0)
            begin nerr++; $display("FAIL b2b_second got v=%b d=%h i=%0d exp v=1 d=0009 i=0", s_out_valid, s_out_data, s_out_index); end
        idle();
    endtask

    task automatic test_mid_reset();
        send(16'd50); send(16'd60);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        nvec++; if (s_out_valid !== 1'b0) begin nerr++; $display("FAIL mid_reset_valid got %b exp 0", s_out_valid); end
        send(16'd1); send(16'd2); send(16'd3);
        nvec++; if (s_out_valid !== 1'b0) begin nerr++; $display("FAIL mid_reset_stale got %b exp 0", s_out_valid); end
        send(16'd4);
        nvec++; if (s_out_valid !== 1'b1 || s_out_data !== 16'd4 || s_out_index !== 2'd3)
            begin nerr++; $display("FAIL mid_reset_group got v=%b d=%h i=%0d exp v=1 d=0004 i=3", s_out_valid, s_out_data, s_out_index); end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_sign_mode();
        test_relu();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
